// File: rtl/timer_array_if.sv
`default_nettype none
// ============================================================================
//  Module      : timer_array_if
//  Description : CPU-side bus bundle for the timer_array block. The CPU
//                (master) drives the per-channel controls, the load strobe and
//                the readback select; the timer (slave) returns the selected
//                counter value, the sticky status flags and the merged irq.
//  Ports       : enable, direction, auto_reload, done_ack, irq_en (CHANNELS)
//                set, set_sel (CH_W), count (WIDTH), prescale (PRESCALE_W)
//                rd_sel (CH_W) -> rd_value (WIDTH), done, overrun, irq
//  Revision    : 1.0  initial multi-channel release
// ============================================================================
interface timer_array_if #(
    parameter int CHANNELS   = 4,
    parameter int WIDTH      = 16,
    parameter int PRESCALE_W = 8
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CHANNELS-1:0]   enable;
    logic [CHANNELS-1:0]   direction;
    logic [CHANNELS-1:0]   auto_reload;
    logic [CHANNELS-1:0]   done_ack;
    logic                  set;
    logic [CH_W-1:0]       set_sel;
    logic [WIDTH-1:0]      count;
    logic [PRESCALE_W-1:0] prescale;
    logic [CHANNELS-1:0]   irq_en;
    logic [CH_W-1:0]       rd_sel;
    logic [WIDTH-1:0]      rd_value;
    logic [CHANNELS-1:0]   done;
    logic [CHANNELS-1:0]   overrun;
    logic                  irq;

    modport master (
        output enable, direction, auto_reload, done_ack, set, set_sel,
               count, prescale, irq_en, rd_sel,
        input  rd_value, done, overrun, irq
    );

    modport slave (
        input  enable, direction, auto_reload, done_ack, set, set_sel,
               count, prescale, irq_en, rd_sel,
        output rd_value, done, overrun, irq
    );
endinterface
`default_nettype wire

// File: rtl/timer_array.sv
`default_nettype none
// ============================================================================
//  Module      : timer_array
//  Description : CHANNELS independent WIDTH-bit up/down timers sharing one
//                programmable prescaler. Each channel has a sticky done flag,
//                overrun detection, optional auto-reload and an interrupt
//                mask; all channels merge into a single irq.
//  Ports       : clk  - clock, rising edge
//                rst  - synchronous active-high reset
//                bus  - timer_array_if.slave (controls, load, readback, status)
//  Revision    : 1.0  initial multi-channel release
// ============================================================================
module timer_array #(
    parameter int CHANNELS   = 4,
    parameter int WIDTH      = 16,
    parameter int PRESCALE_W = 8
) (
    input  wire logic     clk,
    input  wire logic     rst,
    timer_array_if.slave  bus
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [PRESCALE_W-1:0] r_pre_cnt;
    logic [WIDTH-1:0]      r_counter [CHANNELS];
    logic [WIDTH-1:0]      r_reload  [CHANNELS];
    logic [CHANNELS-1:0]   r_armed;
    logic [CHANNELS-1:0]   r_done;
    logic [CHANNELS-1:0]   r_overrun;

    // ------------------------------------------------------------------------
    // Per-channel decode
    // ------------------------------------------------------------------------
    // ">=" rather than "==" so that lowering prescale below the running
    // count still produces a tick on the next cycle instead of a long wrap.
    logic                  w_tick;
    logic [CHANNELS-1:0]   w_sel;
    logic [CHANNELS-1:0]   w_step;
    logic [CHANNELS-1:0]   w_event;
    logic [WIDTH-1:0]      w_term [CHANNELS];

    assign w_tick = (r_pre_cnt >= bus.prescale);

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            // An out-of-range set_sel matches no channel and is thus ignored.
            w_sel[i]   = bus.set && (bus.set_sel == CH_W'(i));
            // Terminal value follows the direction seen this cycle.
            w_term[i]  = bus.direction[i] ? r_reload[i] : '0;
            w_step[i]  = w_tick & bus.enable[i] & r_armed[i];
            w_event[i] = w_step[i] && (r_counter[i] == w_term[i]);
        end
    end

    // ------------------------------------------------------------------------
    // Sequential update
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre_cnt <= '0;
            r_armed   <= '0;
            r_done    <= '0;
            r_overrun <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_counter[i] <= '0;
                r_reload[i]  <= '0;
            end
        end else begin
            r_pre_cnt <= w_tick ? '0 : r_pre_cnt + PRESCALE_W'(1);

            for (int i = 0; i < CHANNELS; i++) begin
                if (w_sel[i]) begin
                    // Load wins over tick and ack; start value uses the
                    // direction and count sampled together with the strobe.
                    r_reload[i]  <= bus.count;
                    r_counter[i] <= bus.direction[i] ? '0 : bus.count;
                    r_armed[i]   <= 1'b1;
                    r_done[i]    <= 1'b0;
                    r_overrun[i] <= 1'b0;
                end else begin
                    if (w_step[i]) begin
                        if (w_event[i]) begin
                            if (bus.auto_reload[i])
                                r_counter[i] <= bus.direction[i] ? '0 : r_reload[i];
                            else
                                r_armed[i] <= 1'b0;
                        end else if (bus.direction[i]) begin
                            r_counter[i] <= r_counter[i] + WIDTH'(1);
                        end else begin
                            r_counter[i] <= r_counter[i] - WIDTH'(1);
                        end
                    end

                    if (w_event[i]) begin
                        // Event beats a simultaneous ack: the ack still wipes
                        // the old overrun, but a second unacknowledged event
                        // re-flags it.
                        r_done[i]    <= 1'b1;
                        r_overrun[i] <= r_done[i] | (r_overrun[i] & ~bus.done_ack[i]);
                    end else if (bus.done_ack[i]) begin
                        r_done[i]    <= 1'b0;
                        r_overrun[i] <= 1'b0;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] w_rd_value;

    always_comb begin
        w_rd_value = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (bus.rd_sel == CH_W'(i))
                w_rd_value = r_counter[i];
        end
    end

    assign bus.rd_value = w_rd_value;
    assign bus.done     = r_done;
    assign bus.overrun  = r_overrun;
    assign bus.irq      = |(r_done & bus.irq_en);

endmodule
`default_nettype wire

// File: tb/tb_timer_array.sv
`default_nettype none
// ============================================================================
//  Module      : tb_timer_array
//  Description : Self-checking bench for timer_array: directed scenarios
//                followed by random traffic, compared every cycle against a
//                behavioural channel model.
//  Revision    : 1.0  initial multi-channel release
// ============================================================================
module tb_timer_array;
    localparam int CH   = 3;
    localparam int W    = 8;
    localparam int PW   = 8;
    localparam int MASK = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    timer_array_if #(.CHANNELS(CH), .WIDTH(W), .PRESCALE_W(PW)) bus ();

    timer_array #(.CHANNELS(CH), .WIDTH(W), .PRESCALE_W(PW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Behavioural model of every channel
    int unsigned m_pre;
    int unsigned m_cnt [CH];
    int unsigned m_rel [CH];
    bit          m_arm [CH];
    bit          m_done[CH];
    bit          m_ovr [CH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic mdl();
        bit tick;
        if (rst) begin
            m_pre = 0;
            for (int c = 0; c < CH; c++) begin
                m_cnt[c] = 0; m_rel[c] = 0; m_arm[c] = 0; m_done[c] = 0; m_ovr[c] = 0;
            end
            return;
        end
        tick  = (m_pre >= int'(bus.prescale));
        m_pre = tick ? 0 : m_pre + 1;
        for (int c = 0; c < CH; c++) begin
            if (bus.set && int'(bus.set_sel) == c) begin
                m_rel[c]  = bus.count;
                m_cnt[c]  = bus.direction[c] ? 0 : int'(bus.count);
                m_arm[c]  = 1;
                m_done[c] = 0;
                m_ovr[c]  = 0;
            end else begin
                bit up, stepping, hit;
                int unsigned goal;
                up       = bus.direction[c];
                goal     = up ? m_rel[c] : 0;
                stepping = tick && bus.enable[c] && m_arm[c];
                hit      = stepping && (m_cnt[c] == goal);
                if (hit) begin
                    if (bus.auto_reload[c]) m_cnt[c] = up ? 0 : m_rel[c];
                    else                    m_arm[c] = 0;
                    m_ovr[c]  = m_done[c] || (m_ovr[c] && !bus.done_ack[c]);
                    m_done[c] = 1;
                end else begin
                    if (stepping) m_cnt[c] = (m_cnt[c] + (up ? 1 : MASK)) & MASK;
                    if (bus.done_ack[c]) begin
                        m_done[c] = 0;
                        m_ovr[c]  = 0;
                    end
                end
            end
        end
    endtask

    // One clock: update model, let the edge pass, compare all outputs.
    task automatic cyc();
        logic [CH-1:0] e_done, e_ovr;
        logic [W-1:0]  e_rd;
        mdl();
        @(posedge clk);
        #1;
        for (int c = 0; c < CH; c++) begin
            e_done[c] = m_done[c];
            e_ovr[c]  = m_ovr[c];
        end
        e_rd = (int'(bus.rd_sel) < CH) ? W'(m_cnt[bus.rd_sel]) : '0;
        chk("rd_value", 32'(bus.rd_value), 32'(e_rd));
        chk("done",     32'(bus.done),     32'(e_done));
        chk("overrun",  32'(bus.overrun),  32'(e_ovr));
        chk("irq",      32'(bus.irq),      32'(|(e_done & bus.irq_en)));
    endtask

    task automatic load(input int ch, input int val);
        bus.set = 1'b1; bus.set_sel = 2'(ch); bus.count = W'(val);
        cyc();
        bus.set = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        bus.enable = '0; bus.direction = '0; bus.auto_reload = '0; bus.done_ack = '0;
        bus.set = 1'b0; bus.set_sel = '0; bus.count = '0; bus.prescale = '0;
        bus.irq_en = '0; bus.rd_sel = '0;
        cyc(); cyc();
        chk("reset_rd",   32'(bus.rd_value), 32'd0);
        chk("reset_done", 32'(bus.done),     32'd0);
        chk("reset_irq",  32'(bus.irq),      32'd0);
        rst = 1'b0;

        // ch0 down from 3, one-shot
        bus.enable = 3'b001;
        load(0, 3);
        chk("t1_rd3", 32'(bus.rd_value), 32'd3);
        cyc(); chk("t1_rd2", 32'(bus.rd_value), 32'd2);
        cyc(); chk("t1_rd1", 32'(bus.rd_value), 32'd1);
        cyc(); chk("t1_rd0", 32'(bus.rd_value), 32'd0);
        chk("t1_done_early", 32'(bus.done[0]), 32'd0);
        cyc(); chk("t1_done", 32'(bus.done[0]), 32'd1);
        repeat (4) cyc();
        chk("t1_hold", 32'(bus.rd_value), 32'd0);
        chk("t1_no_ovr", 32'(bus.overrun[0]), 32'd0);

        // ch1 up, auto-reload, prescale 2: period 6 cycles
        bus.prescale = 8'd2; bus.irq_en = 3'b010;
        bus.direction = 3'b010; bus.auto_reload = 3'b010; bus.enable = 3'b010;
        bus.rd_sel = 2'd1;
        load(1, 1);
        n = 0;
        while (!bus.done[1] && n < 20) begin cyc(); n++; end
        chk("t2_first_done", 32'(bus.done[1]), 32'd1);
        chk("t2_irq", 32'(bus.irq), 32'd1);
        n = 0;
        while (!bus.overrun[1] && n < 20) begin cyc(); n++; end
        chk("t2_period", 32'(n), 32'd6);
        bus.done_ack = 3'b010; cyc(); bus.done_ack = '0;
        chk("t2_ack_done", 32'(bus.done[1]), 32'd0);
        chk("t2_ack_ovr", 32'(bus.overrun[1]), 32'd0);
        chk("t2_ack_irq", 32'(bus.irq), 32'd0);
        bus.enable = '0;

        // ch2: ack held while terminal events happen
        bus.prescale = '0; bus.direction = '0; bus.auto_reload = 3'b100;
        bus.enable = 3'b100; bus.done_ack = 3'b100; bus.rd_sel = 2'd2;
        load(2, 2);
        n = 0;
        while (!bus.done[2] && n < 10) begin cyc(); n++; end
        chk("t3_done", 32'(bus.done[2]), 32'd1);
        chk("t3_ovr", 32'(bus.overrun[2]), 32'd0);
        bus.enable = '0; bus.done_ack = 3'b111; cyc(); bus.done_ack = '0;

        // ch1 and ch2 terminal on the same tick, ch2 masked
        bus.auto_reload = '0; bus.irq_en = 3'b010;
        load(1, 2); load(2, 2);
        bus.enable = 3'b110;
        n = 0;
        while (!bus.done[1] && n < 10) begin cyc(); n++; end
        chk("t4_both_done", 32'(bus.done[2:1]), 32'd3);
        chk("t4_irq", 32'(bus.irq), 32'd1);
        bus.done_ack = 3'b010; cyc(); bus.done_ack = '0;
        chk("t4_irq_masked", 32'(bus.irq), 32'd0);
        chk("t4_ch2_kept", 32'(bus.done[2]), 32'd1);

        // ch0 direction flipped to up mid-count
        bus.enable = 3'b001; bus.rd_sel = 2'd0;
        load(0, 6); cyc(); cyc();
        chk("t5_rd4", 32'(bus.rd_value), 32'd4);
        bus.direction = 3'b001;
        n = 0;
        while (!bus.done[0] && n < 10) begin cyc(); n++; end
        chk("t5_steps", 32'(n), 32'd3);
        chk("t5_rd6", 32'(bus.rd_value), 32'd6);
        bus.direction = '0;

        // out-of-range set and read, then reset mid-count
        bus.set = 1'b1; bus.set_sel = 2'd3; bus.count = 8'd99; cyc(); bus.set = 1'b0;
        bus.rd_sel = 2'd3; cyc();
        chk("t6_rd_oor", 32'(bus.rd_value), 32'd0);
        bus.rd_sel = 2'd0; bus.auto_reload = 3'b001;
        load(0, 40); cyc(); cyc();
        rst = 1'b1; bus.set = 1'b1; bus.set_sel = 2'd0; bus.count = 8'd50;
        bus.done_ack = 3'b111; bus.irq_en = 3'b111;
        cyc();
        rst = 1'b0; bus.set = 1'b0; bus.done_ack = '0;
        chk("t6_rst_rd", 32'(bus.rd_value), 32'd0);
        chk("t6_rst_done", 32'(bus.done), 32'd0);
        chk("t6_rst_irq", 32'(bus.irq), 32'd0);

        // random traffic
        for (int k = 0; k < 1500; k++) begin
            rst = ($urandom_range(0, 199) == 0);
            bus.set = ($urandom_range(0, 7) == 0);
            bus.set_sel = 2'($urandom_range(0, 3));
            bus.count = ($urandom_range(0, 9) == 0) ? W'($urandom) : W'($urandom_range(0, 6));
            bus.enable = 3'($urandom);
            if ($urandom_range(0, 15) == 0) bus.direction   = 3'($urandom);
            if ($urandom_range(0, 15) == 0) bus.auto_reload = 3'($urandom);
            if ($urandom_range(0, 31) == 0) bus.prescale    = PW'($urandom_range(0, 3));
            for (int c = 0; c < CH; c++) bus.done_ack[c] = ($urandom_range(0, 7) == 0);
            bus.irq_en = 3'($urandom);
            bus.rd_sel = 2'($urandom_range(0, 3));
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/timer_array.md
# timer_array

Multi-channel, parametrised successor to the single 16-bit timer. It provides CHANNELS independent up/down timers of WIDTH bits behind one shared programmable prescaler. Each channel has its own sticky done flag, overrun detection, auto-reload and interrupt enable, and all channels are merged into a single irq line for the CPU. Load and readback use a channel-select port, so CPU-side wiring stays narrow.

## Interface
- CHANNELS, 4: number of timer channels, 1..16; CH_W = max(1, $clog2(CHANNELS))
- WIDTH, 16: counter and reload width in bits, 2..32
- PRESCALE_W, 8: prescaler control width
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- enable  in  CHANNELS  per-channel count enable
- direction  in  CHANNELS  per channel: 0 = count down, 1 = count up
- auto_reload  in  CHANNELS  per channel: restart after terminal instead of halting
- done_ack  in  CHANNELS  per channel: clear done and overrun
- set  in  1  load strobe for channel set_sel
- set_sel  in  CH_W  channel targeted by set
- count  in  WIDTH  reload value written on set
- prescale  in  PRESCALE_W  tick period minus one
- irq_en  in  CHANNELS  per-channel interrupt mask
- rd_sel  in  CH_W  channel shown on rd_value
- rd_value  out  WIDTH  current counter of channel rd_sel (combinational mux of registers)
- done  out  CHANNELS  sticky terminal flags
- overrun  out  CHANNELS  sticky: terminal event while done already set
- irq  out  1  |(done & irq_en), combinational from registers

## Operation
- Prescaler: free-running pre_cnt. tick = (pre_cnt >= prescale). On tick, pre_cnt <= 0; otherwise pre_cnt increments. prescale = 0 gives a tick every cycle. A prescale value lowered below pre_cnt produces a tick on the next cycle.
- Per-channel state: counter[WIDTH], reload[WIDTH], armed, done, overrun.
- Start value: reload when direction = 0; 0 when direction = 1.
- Terminal value: 0 when direction = 0; reload when direction = 1.
- set with set_sel < CHANNELS does all of the following for that channel:
  - reload <= count
  - counter <= start value, using direction and count as sampled this cycle
  - armed <= 1
  - done <= 0, overrun <= 0
- set with set_sel >= CHANNELS is ignored.
- Set has priority over tick and done_ack for the selected channel.
- Step condition: tick & enable & armed. On a step:
  - If counter == terminal, this is a terminal event. If auto_reload = 1, counter <= start value; otherwise counter holds and armed <= 0.
  - Otherwise counter steps by ±1, modulo 2^WIDTH.
- A terminal event sets done. If done was already 1 before the event, overrun is also set.
- done_ack clears done and overrun. A terminal event in the same cycle wins: done = 1, and overrun is set only if done was already 1.
- Direction change mid-count takes effect on the next step. Terminal comparison uses the current direction. An up-count above reload wraps through 2^WIDTH-1 to 0 before matching.
- reload = 0 with direction 0: a terminal event occurs on every step when auto_reload = 1.
- A disarmed channel holds its counter and ignores ticks until the next set.
- rd_sel >= CHANNELS reads 0.

## Timing
- Reset values: pre_cnt = 0; every counter = 0, reload = 0, armed = 0, done = 0, overrun = 0; therefore rd_value = 0 and irq = 0.
- rst mid-count aborts all channels immediately. A set or ack in the same cycle as rst is discarded.
- set at edge k: the new counter is visible on rd_value after edge k.
- Terminal event at edge k: done, overrun and irq are visible after edge k.
- Period, for a down channel or an up channel, with auto_reload: (reload + 1) steps = (reload + 1) × (prescale + 1) cycles between done events.
- Ticks are global. The first step after enable rises lands on the next tick; it is not phase-aligned to the enable edge.

## Test plan
- Reset, then prescale = 0, set ch0 with count = 3, direction 0, enable ch0 -> rd_value reads 3, 2, 1, 0 on successive cycles; done[0] rises on the 4th step; counter holds 0; ch0 disarmed, no further events.
- prescale = 2, ch1 up, auto_reload, count = 1, irq_en[1] = 1 -> done[1] and irq first set after 6 cycles. With no ack, the next terminal event (6 cycles later) sets overrun[1]. done_ack[1] clears both; irq drops the next cycle.
- done_ack asserted in the same cycle as a terminal event on ch2 -> done[2] = 1 after the edge; overrun[2] = 0 if done was clear beforehand.
- Two channels hit terminal on the same tick, one with irq_en masked -> both done bits set; irq driven by the unmasked channel only.
- Direction flipped to up mid-count on ch0 (counter = 5, reload = 3) -> counter counts 6 … 2^WIDTH-1, 0 … 3, then done[0] is set.
- set_sel = CHANNELS (out of range) and rd_sel out of range -> no channel state changes; rd_value = 0. rst asserted mid-count -> all outputs return to 0 on the next edge.
